// File: rtl/rf_write_arbiter.sv
// -----------------------------------------------------------------------------
// rf_write_arbiter
//
// Two-port write arbiter in front of a single-write-port register file, with
// a built-in full-clear sequencer.
//
//   - Port A (ALU writeback) has priority over port B (stream-load writeback).
//   - Port B is guaranteed progress: after STARVE_MAX consecutive contentions
//     lost to A, B wins the next contention.
//   - The clear sequencer writes CLR_VALUE to every entry, addresses 0 up to
//     2^ADDR_W-1, one per cycle. It runs after reset and on clr_start.
//
// Grants are combinational. The write to the register file is registered, so
// we/addrd/din appear one cycle after the grant cycle.
//
// Ports
//   clk        in   single clock, rising edge
//   rst_n      in   synchronous active-low reset
//   clr_start  in   request a full register-file clear
//   a_req      in   port A write request
//   a_addr     in   port A write address          [ADDR_W]
//   a_data     in   port A write data             [DATA_W]
//   a_gnt      out  port A accepted this cycle
//   b_req      in   port B write request
//   b_addr     in   port B write address          [ADDR_W]
//   b_data     in   port B write data             [DATA_W]
//   b_gnt      out  port B accepted this cycle
//   we         out  register file write enable
//   addrd      out  register file write address   [ADDR_W]
//   din        out  register file write data      [DATA_W]
//   busy       out  clear sequence in progress
//
// States
//   state | meaning
//   ------+---------------------------------------------------------------
//   CLEAR | sequencer writes CLR_VALUE to entry cc each cycle; no grants
//   RUN   | normal arbitration between ports A and B
// -----------------------------------------------------------------------------
module rf_write_arbiter #(
  parameter int                 ADDR_W     = 5,
  parameter int                 DATA_W     = 2,
  parameter logic [DATA_W-1:0]  CLR_VALUE  = '0,
  parameter int                 STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_start,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_gnt,
  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_gnt,
  output logic              we,
  output logic [ADDR_W-1:0] addrd,
  output logic [DATA_W-1:0] din,
  output logic              busy
);

  // Starvation counter width; a degenerate STARVE_MAX still gets one bit.
  localparam int SC_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SC_W-1:0]   SC_MAX  = SC_W'(STARVE_MAX);
  localparam logic [ADDR_W-1:0] CC_LAST = {ADDR_W{1'b1}};

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cc, cc_nxt;
  logic [SC_W-1:0]   sc, sc_nxt;
  logic              we_nxt;
  logic [ADDR_W-1:0] addrd_nxt;
  logic [DATA_W-1:0] din_nxt;
  logic              hit;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= CLEAR;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers: clear counter, starvation counter, write port
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cc    <= '0;
      sc    <= '0;
      we    <= 1'b0;
      addrd <= '0;
      din   <= '0;
    end else begin
      cc    <= cc_nxt;
      sc    <= sc_nxt;
      we    <= we_nxt;
      addrd <= addrd_nxt;
      din   <= din_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state, grants and next write-port values
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    cc_nxt    = cc;
    a_gnt     = 1'b0;
    b_gnt     = 1'b0;
    busy      = 1'b0;
    we_nxt    = 1'b0;
    addrd_nxt = addrd;
    din_nxt   = din;
    hit       = (sc == SC_MAX);

    case (state)
      CLEAR: begin
        busy      = 1'b1;
        // The write for the current cc is always issued, even on a restart.
        we_nxt    = 1'b1;
        addrd_nxt = cc;
        din_nxt   = CLR_VALUE;
        if (clr_start) begin
          cc_nxt = '0;
        end else begin
          cc_nxt = cc + 1'b1;
          if (cc == CC_LAST) begin
            state_nxt = RUN;
          end
        end
      end

      RUN: begin
        if (clr_start) begin
          cc_nxt    = '0;
          state_nxt = CLEAR;
        end else begin
          // A wins contention unless B has lost STARVE_MAX times in a row.
          a_gnt = a_req & ~(b_req & hit);
          b_gnt = b_req & (~a_req | hit);
          if (a_gnt) begin
            we_nxt    = 1'b1;
            addrd_nxt = a_addr;
            din_nxt   = a_data;
          end else if (b_gnt) begin
            we_nxt    = 1'b1;
            addrd_nxt = b_addr;
            din_nxt   = b_data;
          end
        end
      end

      default: begin
        state_nxt = CLEAR;
        cc_nxt    = '0;
      end
    endcase

    // Counts only contentions that B actually lost; any B grant or B going
    // idle forgives the history. Saturation is a safety net: with hit set,
    // A cannot win a contention, so the increment condition is already false.
    sc_nxt = sc;
    if (!b_req || b_gnt) begin
      sc_nxt = '0;
    end else if (a_req && a_gnt && (sc != SC_MAX)) begin
      sc_nxt = sc + 1'b1;
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 2;

  logic              clk;
  logic              rst_n;
  logic              clr_start;
  logic              a_req;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;
  logic              a_gnt;
  logic              b_req;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_data;
  logic              b_gnt;
  logic              we;
  logic [ADDR_W-1:0] addrd;
  logic [DATA_W-1:0] din;
  logic              busy;

  int tests_run = 0;
  int tests_failed = 0;

  rf_write_arbiter #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .CLR_VALUE (2'b00),
    .STARVE_MAX(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_start(clr_start),
    .a_req    (a_req),
    .a_addr   (a_addr),
    .a_data   (a_data),
    .a_gnt    (a_gnt),
    .b_req    (b_req),
    .b_addr   (b_addr),
    .b_data   (b_data),
    .b_gnt    (b_gnt),
    .we       (we),
    .addrd    (addrd),
    .din      (din),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    int wcount;
    int exp_addr;
    logic exp_a;

    rst_n     = 1'b0;
    clr_start = 1'b0;
    a_req     = 1'b0;
    a_addr    = '0;
    a_data    = '0;
    b_req     = 1'b0;
    b_addr    = '0;
    b_data    = '0;

    // ---------------- reset state
    step();
    step();
    chk("rst_we",    32'(we),    32'd0);
    chk("rst_addrd", 32'(addrd), 32'd0);
    chk("rst_din",   32'(din),   32'd0);
    chk("rst_agnt",  32'(a_gnt), 32'd0);
    chk("rst_bgnt",  32'(b_gnt), 32'd0);
    chk("rst_busy",  32'(busy),  32'd1);

    // ---------------- power-up clear: 32 writes 0..31, busy drops with 31
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      step();
      chk("clr_we",    32'(we),    32'd1);
      chk("clr_addrd", 32'(addrd), 32'(i));
      chk("clr_din",   32'(din),   32'd0);
      chk("clr_busy",  32'(busy),  (i < 31) ? 32'd1 : 32'd0);
    end
    step();
    chk("run_idle_we",   32'(we),   32'd0);
    chk("run_idle_busy", 32'(busy), 32'd0);

    // ---------------- A alone: addr 7 data 2
    a_req = 1'b1; a_addr = 5'd7; a_data = 2'd2;
    #1;
    chk("a_only_agnt", 32'(a_gnt), 32'd1);
    chk("a_only_bgnt", 32'(b_gnt), 32'd0);
    step();
    a_req = 1'b0;
    chk("a_only_we",    32'(we),    32'd1);
    chk("a_only_addrd", 32'(addrd), 32'd7);
    chk("a_only_din",   32'(din),   32'd2);
    step();
    chk("a_only_we_off",  32'(we),    32'd0);
    chk("a_only_hold_ad", 32'(addrd), 32'd7);
    chk("a_only_hold_d",  32'(din),   32'd2);

    // ---------------- B alone: addr 20 data 1
    b_req = 1'b1; b_addr = 5'd20; b_data = 2'd1;
    #1;
    chk("b_only_bgnt", 32'(b_gnt), 32'd1);
    chk("b_only_agnt", 32'(a_gnt), 32'd0);
    step();
    b_req = 1'b0;
    chk("b_only_we",    32'(we),    32'd1);
    chk("b_only_addrd", 32'(addrd), 32'd20);
    chk("b_only_din",   32'(din),   32'd1);

    // ---------------- continuous contention, same address: A,A,A,A,B,...
    a_req = 1'b1; a_addr = 5'd3; a_data = 2'd1;
    b_req = 1'b1; b_addr = 5'd3; b_data = 2'd2;
    for (int k = 0; k < 10; k++) begin
      exp_a = ((k % 5) != 4);
      #1;
      chk("cont_agnt", 32'(a_gnt), 32'(exp_a));
      chk("cont_bgnt", 32'(b_gnt), 32'(!exp_a));
      chk("cont_both", 32'(a_gnt & b_gnt), 32'd0);
      step();
      chk("cont_we",    32'(we),    32'd1);
      chk("cont_addrd", 32'(addrd), 32'd3);
      chk("cont_din",   32'(din),   exp_a ? 32'd1 : 32'd2);
    end

    // ---------------- B dropping its request forgives lost contentions
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("forg_pre_agnt", 32'(a_gnt), 32'd1);
      step();
    end
    b_req = 1'b0;
    #1;
    chk("forg_idle_agnt", 32'(a_gnt), 32'd1);
    step();
    b_req = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("forg_agnt", 32'(a_gnt), (k < 4) ? 32'd1 : 32'd0);
      chk("forg_bgnt", 32'(b_gnt), (k < 4) ? 32'd0 : 32'd1);
      step();
    end
    a_req = 1'b0;
    b_req = 1'b0;
    step();

    // ---------------- clr_start with A request: A blocked, granted after clear
    clr_start = 1'b1;
    a_req = 1'b1; a_addr = 5'd9; a_data = 2'd3;
    #1;
    chk("clrA_agnt", 32'(a_gnt), 32'd0);
    chk("clrA_bgnt", 32'(b_gnt), 32'd0);
    step();
    clr_start = 1'b0;
    chk("clrA_busy", 32'(busy), 32'd1);
    chk("clrA_we",   32'(we),   32'd0);
    for (int i = 0; i < 32; i++) begin
      step();
      chk("clrA_seq_we",    32'(we),    32'd1);
      chk("clrA_seq_addrd", 32'(addrd), 32'(i));
      chk("clrA_seq_agnt",  32'(a_gnt), (i == 31) ? 32'd1 : 32'd0);
    end
    step();
    a_req = 1'b0;
    chk("clrA_wr_we",    32'(we),    32'd1);
    chk("clrA_wr_addrd", 32'(addrd), 32'd9);
    chk("clrA_wr_din",   32'(din),   32'd3);

    // ---------------- restart clear at cc=10: 0..10 then 0..31 = 43 writes
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    chk("rst10_busy", 32'(busy), 32'd1);
    wcount = 0;
    n = 0;
    while (n < 100) begin
      if (n == 10) clr_start = 1'b1;
      step();
      clr_start = 1'b0;
      if (we) wcount++;
      exp_addr = (n < 11) ? n : n - 11;
      chk("rst10_addrd", 32'(addrd), 32'(exp_addr));
      n++;
      if (!busy) break;
    end
    chk("rst10_count", 32'(wcount), 32'd43);
    chk("rst10_last",  32'(addrd),  32'd31);

    // ---------------- reset mid-RUN during a B grant: transfer dropped
    step();
    b_req = 1'b1; b_addr = 5'd17; b_data = 2'd3;
    #1;
    chk("rstB_bgnt", 32'(b_gnt), 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    b_req = 1'b0;
    chk("rstB_we",    32'(we),    32'd0);
    chk("rstB_addrd", 32'(addrd), 32'd0);
    chk("rstB_din",   32'(din),   32'd0);
    chk("rstB_busy",  32'(busy),  32'd1);
    step();
    chk("rstB_clr0_we",    32'(we),    32'd1);
    chk("rstB_clr0_addrd", 32'(addrd), 32'd0);
    step();
    chk("rstB_clr1_addrd", 32'(addrd), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
